// File: rtl/random_gen_if.sv
// Control and status bundle for random_gen: seeding, step mode, match inputs,
// draw request and the drawn result.
interface random_gen_if #(
   parameter int WIDTH = 16,
   parameter int OUT_W = 3,
   parameter int POS_W = 10
);
   logic [WIDTH-1:0] seed;
   logic             seed_ld;
   logic [1:0]       mode;
   logic [POS_W-1:0] position;
   logic [POS_W-1:0] limit;
   logic             req;
   logic [OUT_W-1:0] range;
   logic [WIDTH-1:0] state;
   logic [OUT_W-1:0] rnd;
   logic             rnd_valid;
   logic             busy;

   modport master (
      output seed, seed_ld, mode, position, limit, req, range,
      input  state, rnd, rnd_valid, busy
   );

   modport slave (
      input  seed, seed_ld, mode, position, limit, req, range,
      output state, rnd, rnd_valid, busy
   );
endinterface

// File: rtl/random_gen.sv
// Fibonacci LFSR with mode-controlled stepping and a rejection-sampling draw FSM
// that keeps stepping until the low OUT_W bits fall below the requested range.
module random_gen #(
   parameter int          WIDTH      = 16,
   parameter logic [31:0] TAPS       = 32'h0000_B400,
   parameter int          OUT_W      = 3,
   parameter int          POS_W      = 10,
   parameter logic [31:0] RESET_SEED = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   random_gen_if.slave bus
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SEARCH = 1'b1
   } fsm_t;

   localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] L_TAPS = TAPS[WIDTH-1:0];
   localparam logic [WIDTH-1:0] L_SEED = RESET_SEED[WIDTH-1:0];

   fsm_t             r_fsm;
   fsm_t             w_fsm_nxt;
   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] w_state_nxt;
   logic [WIDTH-1:0] w_seed_val;
   logic             r_prev_match;
   logic             w_match;
   logic             w_match_edge;
   logic [OUT_W-1:0] w_cand;
   logic             w_accept;
   logic             w_rnd_ld;
   logic [OUT_W-1:0] r_rnd;
   logic             r_rnd_valid;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & L_TAPS)};
   endfunction

   assign w_match      = (bus.position == bus.limit);
   assign w_match_edge = w_match && !r_prev_match;
   assign w_seed_val   = (bus.seed == '0) ? L_ONE : bus.seed;
   assign w_cand       = r_state[OUT_W-1:0];
   assign w_accept     = (bus.range == '0) || (w_cand < bus.range);

   // Draw FSM: seed_ld aborts any search and cancels a same-cycle accept.
   always_comb begin
      w_fsm_nxt = r_fsm;
      w_rnd_ld  = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            if (bus.req) w_fsm_nxt = S_SEARCH;
         end
         S_SEARCH: begin
            if (w_accept) begin
               w_fsm_nxt = S_IDLE;
               w_rnd_ld  = 1'b1;
            end
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
      if (bus.seed_ld) begin
         w_fsm_nxt = S_IDLE;
         w_rnd_ld  = 1'b0;
      end
   end

   // Seed load beats zero-recovery, which beats any step.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.seed_ld) begin
         w_state_nxt = w_seed_val;
      end else if (r_state == '0) begin
         w_state_nxt = L_ONE;
      end else if (r_fsm == S_SEARCH) begin
         w_state_nxt = lfsr_step(r_state);
      end else begin
         case (bus.mode)
            2'b01:   if (w_match_edge) w_state_nxt = lfsr_step(r_state);
            2'b10:   w_state_nxt = lfsr_step(r_state);
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fsm        <= S_IDLE;
         r_state      <= L_SEED;
         r_prev_match <= 1'b0;
         r_rnd        <= '0;
         r_rnd_valid  <= 1'b0;
      end else begin
         r_fsm        <= w_fsm_nxt;
         r_state      <= w_state_nxt;
         r_prev_match <= w_match;
         r_rnd_valid  <= w_rnd_ld;
         if (w_rnd_ld) r_rnd <= w_cand;
      end
   end

   assign bus.state     = r_state;
   assign bus.rnd       = r_rnd;
   assign bus.rnd_valid = r_rnd_valid;
   assign bus.busy      = (r_fsm == S_SEARCH);

endmodule

// File: doc/random_gen.md
RANDOM_GEN -- requirements
Module: random_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR width, range 3..32.
REQ-002 Parameter TAPS, default 16'hB400: Fibonacci feedback mask; bit i set means state[i] enters the XOR.
REQ-003 Parameter OUT_W, default 3: width of the drawn value; SHALL be less than WIDTH.
REQ-004 Parameter POS_W, default 10: width of position and limit.
REQ-005 Parameter RESET_SEED, default 1: state after reset; SHALL be nonzero.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 seed  input  WIDTH  value loaded on seed_ld.
REQ-009 seed_ld  input  1  synchronous seed load strobe.
REQ-010 mode  input  2  step mode: 00 hold, 01 match-edge, 10 free-run, 11 draw-only.
REQ-011 position  input  POS_W  scan position.
REQ-012 limit  input  POS_W  match value for mode 01.
REQ-013 req  input  1  draw request strobe.
REQ-014 range  input  OUT_W  draw bound: accepts values below range; 0 means full range.
REQ-015 state  output  WIDTH  current LFSR state, registered.
REQ-016 rnd  output  OUT_W  last accepted draw, registered.
REQ-017 rnd_valid  output  1  one-cycle pulse when rnd updates.
REQ-018 busy  output  1  high while the FSM is in SEARCH.

Function
REQ-019 A step SHALL set state to {state[WIDTH-2:0], fb}, where fb is the XOR-reduce of (state & TAPS).
REQ-020 In IDLE, the mode SHALL control stepping as follows.
- 00: state holds.
- 01: one step on each cycle where position==limit and the registered previous compare was false.
- 10: one step every cycle.
- 11: state holds.
REQ-021 The previous-compare register for mode 01 SHALL update every cycle, regardless of mode.
REQ-022 A match held for N consecutive cycles SHALL produce exactly one step in mode 01.
REQ-023 The FSM SHALL have two states, IDLE and SEARCH; busy SHALL be high exactly in SEARCH.
REQ-024 IDLE SHALL go to SEARCH when req=1 and seed_ld=0; req in SEARCH SHALL be ignored.
REQ-025 In SEARCH, state SHALL step every cycle, regardless of mode.
REQ-026 Each SEARCH cycle SHALL test cand = state[OUT_W-1:0]; the cycle accepts if range==0 or cand<range (unsigned).
REQ-027 On accept, rnd SHALL load cand, rnd_valid SHALL be 1 for the following cycle only, and the FSM SHALL return to IDLE.
REQ-028 On reject, the FSM SHALL stay in SEARCH; no timeout is provided.
REQ-029 Minimum draw latency SHALL be: req sampled on edge k, rnd_valid high after edge k+1.
REQ-030 seed_ld SHALL have the highest priority.
- It loads seed, or 1 if seed==0.
- It forces the FSM to IDLE with no rnd_valid, aborting any SEARCH.
- It suppresses any mode step that cycle.
REQ-031 No step SHALL occur on a seed_ld cycle.
REQ-032 If state is ever 0, the next edge SHALL load 1, overriding any step.
REQ-033 rnd SHALL hold its value between accepts; rnd_valid SHALL be low except as in REQ-027.

Reset
REQ-034 While rst=0, the block SHALL immediately and asynchronously set the following, independent of clk:
- state = RESET_SEED;
- FSM = IDLE, busy = 0;
- rnd = 0, rnd_valid = 0;
- previous-compare register = 0.
REQ-035 Deasserting rst mid-SEARCH SHALL resume in IDLE with no pending draw.
REQ-036 The first edge after rst rises SHALL behave as a normal cycle.

Verification
REQ-037 Sequence check: WIDTH=3, TAPS=3'b110, seed_ld with seed=3'b001, mode=10. state SHALL read 010,101,011,111,110,100,001 and then repeat, giving period 7.
REQ-038 Zero-seed check: defaults, seed_ld with seed=0. state SHALL read 16'h0001, then 16'h0002 after one free-run step.
REQ-039 Match-edge check: mode=01, limit=5, position=5 held 3 cycles, then 6, then 5 again. Exactly 2 steps SHALL occur in total, 1 per match entry.
REQ-040 Rejection draw: WIDTH=3, TAPS=3'b110, OUT_W=2, state=001, range=1, req pulsed. The bench SHALL observe:
- busy high for 7 cycles;
- rnd_valid pulse with rnd=0;
- state=001 afterward.
REQ-041 Full-range draw: range=0, state=3'b101, OUT_W=2. The bench SHALL observe one SEARCH cycle, rnd=2'b01, rnd_valid one cycle after the accept, busy high one cycle.
REQ-042 Abort and reset: assert seed_ld=1 with seed=3'b011 in the 3rd SEARCH cycle. The bench SHALL observe busy low next cycle, no rnd_valid, state=011. Then drive rst low mid-draw: all outputs SHALL reach reset values without a clk edge.
